tmp_edge_counter: RTL and testbench
===================================

TMP_EDGE_COUNTER -- requirements
Module: tmp_edge_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 10: width of the result code.
REQ-002 SHALL have parameter WIN_LEN, default 1023: length of the counting window, in clk cycles (>=1).
REQ-003 SHALL have parameter SETTLE_LEN, default 4: number of blanking cycles before the window (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all flops on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmp  input  1  comparator output from the sensor front-end; asynchronous to clk.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a conversion.
REQ-008 SHALL have port abort  input  1  cancels an in-flight conversion.
REQ-009 SHALL have port code  output  CNT_W  result: count of cmp rising edges within the window.
REQ-010 SHALL have port code_valid  output  1  code holds an unconsumed result.
REQ-011 SHALL have port code_ready  input  1  consumer accepts code when code_valid&code_ready.
REQ-012 SHALL have port overflow  output  1  saturation flag, qualified by code_valid.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL synchronise cmp through two flops (s1, s2) plus one history flop (s3); event = s2 & ~s3.
REQ-015 SHALL implement states IDLE, SETTLE, COUNT, HOLD.
REQ-016 In IDLE, start=1 SHALL move the block to SETTLE on the next edge and clear the settle counter; start SHALL be ignored in all other states.
REQ-017 SETTLE SHALL last exactly SETTLE_LEN cycles and ignore events, then enter COUNT with the edge counter and overflow accumulator cleared.
REQ-018 COUNT SHALL last exactly WIN_LEN cycles and add 1 per event, including an event in the final cycle.
REQ-019 The edge counter SHALL saturate at 2^CNT_W-1; an event at saturation SHALL set the overflow accumulator, which is sticky for that conversion.
REQ-020 At the end of the window, if code_valid=0 or (code_valid & code_ready) in that cycle, the block SHALL load code/overflow, assert code_valid next cycle, and go to IDLE; otherwise it SHALL go to HOLD.
REQ-021 HOLD SHALL ignore events and hold the result until the cycle in which code_valid=0 or code_ready=1, then load the output register and go to IDLE.
REQ-022 code_valid SHALL stay high until a handshake cycle; code and overflow SHALL be stable while code_valid=1.
REQ-023 A handshake with no simultaneous load SHALL clear code_valid next cycle; a handshake with a simultaneous load SHALL keep code_valid=1 and present the new code.
REQ-024 start in IDLE SHALL be accepted while code_valid=1, giving one-deep pipelining.
REQ-025 abort in SETTLE, COUNT or HOLD SHALL return the block to IDLE next cycle, discard the partial result, and leave the output register untouched; abort SHALL have priority over a load in the same cycle; abort in IDLE SHALL have no effect.
REQ-026 Total latency from start accepted to code_valid SHALL be SETTLE_LEN+WIN_LEN+1 cycles when not back-pressured.

Reset
REQ-027 reset_n=0 SHALL immediately force the following, independent of clk: state=IDLE, all counters=0, s1/s2/s3=0, code=0, code_valid=0, overflow=0, busy=0.
REQ-028 Reset asserted mid-conversion SHALL discard all results; after release the block SHALL wait in IDLE for start.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL need no initial blocks.

Verification (CNT_W=3, WIN_LEN=16, SETTLE_LEN=2 unless noted)
REQ-030 Bench: exactly 5 synchronised cmp rising edges inside the window with code_ready=1 -> code=5, overflow=0, code_valid high for 1 cycle, 19 cycles after start.
REQ-031 Bench: cmp toggled every cycle throughout the window (8 events) -> code=7, overflow=1.
REQ-032 Bench: code_ready=0, two back-to-back conversions -> second enters HOLD with busy=1; raise code_ready -> first code accepted, second code presented the same edge, code_valid stays 1, busy falls.
REQ-033 Bench: cmp edges only during SETTLE and HOLD -> the counts reported are unaffected (0 if none are in the window).
REQ-034 Bench: abort at COUNT cycle 8 -> busy=0 next cycle, no code_valid pulse, a prior pending code is preserved.
REQ-035 Bench: reset_n pulsed low between clock edges during COUNT -> all outputs 0 before the next clk edge; a new start after release gives a correct code.

Source files
------------

// File: rtl/tmp_edge_counter.sv
// -----------------------------------------------------------------------------
// tmp_edge_counter
//
// Time-to-digital style edge counter for a sensor front-end. A conversion is
// started with a one-cycle start request. The block then blanks for SETTLE_LEN
// cycles so the front-end can settle. After that it counts synchronised rising
// edges of cmp over a window of WIN_LEN cycles. The count saturates at
// 2^CNT_W-1 with a sticky overflow flag. It is handed to the consumer through
// a one-entry valid/ready output register.
//
// If the output register still holds an unconsumed result when a window ends,
// the new result is parked in HOLD until the register frees up. This gives
// one-deep pipelining of conversions.
//
// Parameters
//   CNT_W       width of the result code
//   WIN_LEN     counting window length in clk cycles (>= 1)
//   SETTLE_LEN  blanking cycles before the window (>= 1)
//
// Ports
//   clk         single clock, all flops on its rising edge
//   reset_n     asynchronous active-low reset (release synchronised externally)
//   cmp         comparator output, asynchronous to clk
//   start       one-cycle conversion request, honoured only in IDLE
//   abort       cancels an in-flight conversion (no effect in IDLE)
//   code        result: number of cmp rising edges seen in the window
//   code_valid  code/overflow hold an unconsumed result
//   code_ready  consumer accepts code when code_valid & code_ready
//   overflow    edge counter saturated during the window (qualified by code_valid)
//   busy        high whenever the block is not in IDLE
// -----------------------------------------------------------------------------
module tmp_edge_counter #(
    parameter int CNT_W      = 10,
    parameter int WIN_LEN    = 1023,
    parameter int SETTLE_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmp,
    input  logic             start,
    input  logic             abort,
    output logic [CNT_W-1:0] code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             overflow,
    output logic             busy
);

    // Counter widths are sized to hold the full length, not just length-1,
    // so a length of 1 still yields a legal non-zero width.
    localparam int SET_W = $clog2(SETTLE_LEN + 1);
    localparam int WIN_W = $clog2(WIN_LEN + 1);

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WIN_LEN - 1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_COUNT  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    logic             s1;
    logic             s2;
    logic             s3;
    logic             sync_event;

    logic [SET_W-1:0] settle_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_acc;

    logic             at_max;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             out_free;
    logic             win_done;
    logic             load;
    logic [CNT_W-1:0] load_code;
    logic             load_ovf;

    // -------------------------------------------------------------------------
    // cmp synchroniser: s1/s2 resolve metastability.
    // s3 is history, so a rising edge is a one-cycle event on s2 & ~s3.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // flop samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cmp;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_event = s2 & ~s3;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    assign at_max   = (edge_cnt == CNT_MAX);
    assign cnt_next = (sync_event && !at_max) ? (edge_cnt + CNT_ONE) : edge_cnt;
    assign ovf_next = ovf_acc | (sync_event & at_max);

    // The output register can take a new result this cycle when it is empty
    // or is being drained by a handshake in this same cycle.
    assign out_free = ~code_valid | code_ready;
    assign win_done = (state == ST_COUNT) && (win_cnt == WIN_LAST);

    // abort wins over a load in the same cycle.
    assign load = !abort && out_free && (win_done || (state == ST_HOLD));

    // In the final window cycle the count is still being updated, so take the
    // look-ahead value; in HOLD the accumulator is already final.
    assign load_code = (state == ST_HOLD) ? edge_cnt : cnt_next;
    assign load_ovf  = (state == ST_HOLD) ? ovf_acc  : ovf_next;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_nxt is given a default before the case, so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (win_cnt == WIN_LAST) begin
                    state_nxt = out_free ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort || out_free) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Settle / window / edge counters
    // Counters are cleared on entry to their phase, so an abort needs no
    // explicit cleanup: stale contents are never observed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            ovf_acc    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_ONE;
                    if (settle_cnt == SETTLE_LAST) begin
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        ovf_acc  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    win_cnt  <= win_cnt + WIN_ONE;
                    edge_cnt <= cnt_next;
                    ovf_acc  <= ovf_next;
                end
                default: begin
                    // HOLD: freeze the result, ignore events.
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A load only happens when the register is free, so code
    // and overflow never change under an unconsumed result. A load together
    // with a handshake keeps code_valid high and presents the new code.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code       <= '0;
            overflow   <= 1'b0;
            code_valid <= 1'b0;
        end else if (load) begin
            code       <= load_code;
            overflow   <= load_ovf;
            code_valid <= 1'b1;
        end else if (code_valid && code_ready) begin
            code_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tmp_edge_counter.sv
// -----------------------------------------------------------------------------
// tb_tmp_edge_counter
//
// Directed bench for tmp_edge_counter with CNT_W=3, WIN_LEN=16, SETTLE_LEN=2.
// Cycle 0 of a conversion is the cycle in which start is driven high.
//   - SETTLE occupies cycles 1-2.
//   - COUNT occupies cycles 3-18.
//   - code_valid rises in cycle 19.
// A cmp rise driven in cycle k becomes an event in cycle k+2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tmp_edge_counter;

    logic       clk;
    logic       reset_n;
    logic       cmp;
    logic       start;
    logic       abort;
    logic [2:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       overflow;
    logic       busy;

    int          n_compared;
    int          n_mismatched;
    logic [63:0] cmp_pat;
    int          cyc;

    tmp_edge_counter #(
        .CNT_W      (3),
        .WIN_LEN    (16),
        .SETTLE_LEN (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmp        (cmp),
        .start      (start),
        .abort      (abort),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; cmp follows the current pattern for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cmp = (cyc < 64) ? cmp_pat[cyc] : 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Pulse start with the given cmp pattern; returns in cycle 1.
    task automatic launch(input logic [63:0] pat);
        cmp_pat = pat;
        cyc     = 0;
        cmp     = pat[0];
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                             input logic o, input logic b);
        check({tag, ".valid"}, 32'(code_valid), 32'(v));
        check({tag, ".code"},  32'(code),       32'(c));
        check({tag, ".ovf"},   32'(overflow),   32'(o));
        check({tag, ".busy"},  32'(busy),       32'(b));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        cmp_pat      = '0;
        cyc          = 0;
        reset_n      = 1'b0;
        cmp          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        code_ready   = 1'b1;

        // Reset state
        #12;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick_n(3);
        check_out("post_reset", 1'b0, 3'd0, 1'b0, 1'b0);

        // 5 events, ready=1, plus a start during COUNT that must be ignored.
        // The result must appear exactly 19 cycles after start.
        launch(64'h554);
        tick_n(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_n(7);
        check("five.c18_valid", 32'(code_valid), 32'd0);
        check("five.c18_busy",  32'(busy),       32'd1);
        tick();
        check_out("five.c19", 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        check("five.c20_valid", 32'(code_valid), 32'd0);
        check("five.c20_busy",  32'(busy),       32'd0);
        tick_n(3);

        // Toggle every cycle: 8 events saturate a 3-bit count.
        launch(64'hAAAA);
        tick_n(18);
        check_out("sat8", 1'b1, 3'd7, 1'b1, 1'b0);
        tick_n(4);

        // Exactly 7 events: full scale without overflow.
        launch(64'h2AAA);
        tick_n(18);
        check_out("sat7", 1'b1, 3'd7, 1'b0, 1'b0);
        tick_n(4);

        // Edges only in SETTLE (cycle 2) and after the window (cycle 19).
        launch(64'h2_0001);
        tick_n(18);
        check_out("outside", 1'b1, 3'd0, 1'b0, 1'b0);
        tick_n(4);

        // Events in the first (3) and last (18) window cycles.
        launch(64'h1_0002);
        tick_n(18);
        check_out("window_ends", 1'b1, 3'd2, 1'b0, 1'b0);
        tick_n(4);

        // Back-pressure: A=3 stays pending, B=2 parks in HOLD.
        // Events in HOLD (cycles 21, 23) are ignored.
        code_ready = 1'b0;
        launch(64'h54);
        tick_n(18);
        check_out("bp.a", 1'b1, 3'd3, 1'b0, 1'b0);
        launch(64'h28_000A);
        tick_n(9);
        check_out("bp.b10", 1'b1, 3'd3, 1'b0, 1'b1);
        tick_n(8);
        check_out("bp.b18", 1'b1, 3'd3, 1'b0, 1'b1);
        tick();
        check_out("bp.hold19", 1'b1, 3'd3, 1'b0, 1'b1);
        tick_n(6);
        check_out("bp.hold25", 1'b1, 3'd3, 1'b0, 1'b1);
        code_ready = 1'b1;
        tick();
        check_out("bp.swap", 1'b1, 3'd2, 1'b0, 1'b0);
        tick();
        check("bp.drain_valid", 32'(code_valid), 32'd0);
        tick_n(4);

        // Abort at COUNT cycle 8 while code C=6 is pending.
        code_ready = 1'b0;
        launch(64'h1554);
        tick_n(18);
        check_out("abort.c", 1'b1, 3'd6, 1'b0, 1'b0);
        launch(64'hAAAA);
        tick_n(9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("abort.next", 1'b1, 3'd6, 1'b0, 1'b0);
        tick_n(10);
        check_out("abort.later", 1'b1, 3'd6, 1'b0, 1'b0);
        code_ready = 1'b1;
        tick();
        check("abort.drain_valid", 32'(code_valid), 32'd0);
        tick_n(3);

        // abort in IDLE has no effect, even alongside start.
        abort = 1'b1;
        launch(64'h14);
        abort = 1'b0;
        check("idle_abort.busy", 32'(busy), 32'd1);
        tick_n(18);
        check_out("idle_abort.res", 1'b1, 3'd2, 1'b0, 1'b0);
        tick_n(4);

        // Async reset between edges during COUNT, with code 5 pending.
        code_ready = 1'b0;
        launch(64'h554);
        tick_n(18);
        check_out("rst.pending", 1'b1, 3'd5, 1'b0, 1'b0);
        launch(64'hAAAA);
        tick_n(9);
        check("rst.busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #2;
        check_out("rst.async", 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        cmp_pat = '0;
        cmp     = 1'b0;
        tick_n(4);
        check_out("rst.idle", 1'b0, 3'd0, 1'b0, 1'b0);
        code_ready = 1'b1;
        launch(64'h154);
        tick_n(18);
        check_out("rst.after", 1'b1, 3'd4, 1'b0, 1'b0);
        tick();
        check("rst.after_drain", 32'(code_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
